sevseg_scan_ctrl: RTL

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It shares one registered BCD-to-segment decoder among N digits. It cycles active-low digit enables with a per-digit on-time and an anti-ghosting blank gap. New display values are loaded through a tear-free, frame-synchronous handshake. It sits between the numeric datapath (counters, BCD converters) and the board pins.

---
 rtl/sevseg_pkg.sv | 22 ++
 rtl/sevseg_digit_decode.sv | 24 ++
 rtl/sevseg_scan_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sevseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sevseg_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {a,b,c,d,e,f,g,dp} patterns for digits 9 down to 0, dp off.
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'b00001001,
    8'b00000001,
    8'b00011111,
    8'b01000001,
    8'b01001001,
    8'b10011001,
    8'b00001101,
    8'b00100101,
    8'b10011111,
    8'b00000011
  };

endpackage

// File: rtl/sevseg_digit_decode.sv
// Registered BCD nibble + decimal point to active-low segment decoder.
module sevseg_digit_decode
  import sevseg_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  // Non-BCD codes go fully dark, decimal point included.
  always_ff @(posedge CLK) begin
    if (RST) begin
      seg <= SEG_BLANK;
    end else if (blank || (nibble > 4'd9)) begin
      seg <= SEG_BLANK;
    end else begin
      seg <= {SEG_TABLE[nibble][7:1], ~dp};
    end
  end

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display.
// Define SEVSEG_LZ_BLANK_EN to blank leading zeros above the top non-zero digit.
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic [4*N_DIGITS-1:0] VALUE,
  input  logic [N_DIGITS-1:0]   DP,
  input  logic                  LOAD,
  output logic                  LOAD_ACK,
  output logic                  FRAME_DONE,
  output logic [7:0]            SEG,
  output logic [N_DIGITS-1:0]   AN
);

  localparam int MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam int IW = $clog2(N_DIGITS);

  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] ON_PRELAST = CW'(ON_CYCLES - 2);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  scan_state_e state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [4*N_DIGITS-1:0] disp, pend_val;
  logic [N_DIGITS-1:0]   disp_dp, pend_dp;
  logic                  pend_flag;

  logic apply_edge;
  logic frame_last_n;
  logic lz_blank;
  logic [3:0] cur_nibble;
  logic cur_dp;
  logic dec_blank;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
    end
  end

  // Dropping ENABLE aborts from any state; the counters restart at digit 0.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt;
    apply_edge   = 1'b0;
    frame_last_n = 1'b0;
    if (!ENABLE) begin
      state_n = IDLE;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = BLANK;
          idx_n   = '0;
          cnt_n   = '0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_n    = SHOW;
            cnt_n      = '0;
            apply_edge = (idx == '0);
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        SHOW: begin
          frame_last_n = (idx == IDX_LAST) && (cnt == ON_PRELAST);
          if (cnt == ON_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
            idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // A capture on the apply edge lands after the old pending value is taken.
  always_ff @(posedge CLK) begin
    if (RST) begin
      disp      <= '1;
      disp_dp   <= '0;
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_flag <= 1'b0;
      LOAD_ACK  <= 1'b0;
    end else begin
      LOAD_ACK <= 1'b0;
      if (apply_edge && pend_flag) begin
        disp      <= pend_val;
        disp_dp   <= pend_dp;
        pend_flag <= 1'b0;
        LOAD_ACK  <= 1'b1;
      end
      if (LOAD) begin
        pend_val  <= VALUE;
        pend_dp   <= DP;
        pend_flag <= 1'b1;
      end
    end
  end

`ifdef SEVSEG_LZ_BLANK_EN
  logic [IW-1:0] msnz;

  always_comb begin
    msnz = '0;
    for (int k = 1; k < N_DIGITS; k++) begin
      if (disp[4*k +: 4] != 4'd0) begin
        msnz = IW'(k);
      end
    end
    lz_blank = (idx > msnz);
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign cur_nibble = disp[{idx, 2'b00} +: 4];
  assign cur_dp     = disp_dp[idx];
  assign dec_blank  = (state != SHOW) || lz_blank;

  // AN and FRAME_DONE share the decoder's single register stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      AN         <= '1;
      FRAME_DONE <= 1'b0;
    end else begin
      AN         <= (state == SHOW) ? ~(N_DIGITS'(1) << idx) : '1;
      FRAME_DONE <= frame_last_n;
    end
  end

  sevseg_digit_decode u_decode (
    .CLK    (CLK),
    .RST    (RST),
    .nibble (cur_nibble),
    .dp     (cur_dp),
    .blank  (dec_blank),
    .seg    (SEG)
  );

endmodule
